// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle shared by the arbiter and its surroundings.
// Latency: none, wires only.
// Backpressure: req_ready / rsp_ready travel with their valid lines.
interface alu_arbiter_if #(
    parameter int N = 16,
    parameter int M = 4
);
    // request side
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req1_a;
    logic [N-1:0] req0_b;
    logic [N-1:0] req1_b;
    logic         req0_cin;
    logic         req1_cin;
    logic [M-1:0] req0_mode;
    logic [M-1:0] req1_mode;

    // ALU side
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_cin;
    logic [M-1:0] alu_mode;
    logic [N-1:0] alu_y;
    logic         alu_cout;
    logic         alu_ovf;

    // response side
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_y;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic [15:0]  op_count;

    // arbiter view
    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_cin, req1_cin, req0_mode, req1_mode,
               alu_y, alu_cout, alu_ovf, rsp_ready,
        output req_ready, alu_a, alu_b, alu_cin, alu_mode,
               rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_ovf, op_count
    );

    // requesters / ALU / consumer view
    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_cin, req1_cin, req0_mode, req1_mode,
               alu_y, alu_cout, alu_ovf, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_cin, alu_mode,
               rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_ovf, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one external ALU; optional round-robin via `ALU_ARB_RR_EN.
// Latency: accept -> one EXEC cycle -> rsp_valid in the following cycle (1 op per 3 cycles max).
// Backpressure: req_ready only in IDLE for the granted port; RESP holds until rsp_ready.
module alu_arbiter #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   state;
    logic         last_grant;
    logic         grant;
    logic         take;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic         sel_cin;
    logic [M-1:0] sel_mode;

    // Pick the winner among valid ports; grant is don't-care when nothing is valid.
    always_comb begin
        grant = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (bus.req_valid == 2'b11)
            grant = ~last_grant;
        else
            grant = bus.req_valid[1] & ~bus.req_valid[0];
`else
        // Port 0 always wins; with nothing valid grant parks on last_grant.
        if (bus.req_valid[0])
            grant = 1'b0;
        else
            grant = bus.req_valid[1] | last_grant;
`endif
    end

    // Accept only in IDLE, and only on the granted port.
    always_comb begin
        take          = (state == S_IDLE) && (|bus.req_valid);
        bus.req_ready = 2'b00;
        if (take)
            bus.req_ready = grant ? 2'b10 : 2'b01;
    end

    // Operand mux for the granted port.
    always_comb begin
        sel_a    = grant ? bus.req1_a    : bus.req0_a;
        sel_b    = grant ? bus.req1_b    : bus.req0_b;
        sel_cin  = grant ? bus.req1_cin  : bus.req0_cin;
        sel_mode = grant ? bus.req1_mode : bus.req0_mode;
    end

    // Sequencer: IDLE -> EXEC -> RESP -> IDLE, tracking the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state      <= S_EXEC;
                        last_grant <= grant;
                    end
                end
                S_EXEC: state <= S_RESP;
                S_RESP: begin
                    if (bus.rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ALU operands change only on accept, so the ALU sees quiet inputs otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_cin  <= 1'b0;
            bus.alu_mode <= '0;
        end else if (take) begin
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_cin  <= sel_cin;
            bus.alu_mode <= sel_mode;
        end
    end

    // Response register: id on accept, result at end of EXEC, valid through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
        end else begin
            if (take)
                bus.rsp_id <= grant;
            if (state == S_EXEC) begin
                bus.rsp_y     <= bus.alu_y;
                bus.rsp_cout  <= bus.alu_cout;
                bus.rsp_ovf   <= bus.alu_ovf;
                bus.rsp_valid <= 1'b1;
            end else if ((state == S_RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

    // Completed-response counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.op_count <= '0;
        else if ((state == S_RESP) && bus.rsp_ready)
            bus.op_count <= bus.op_count + 16'd1;
    end

endmodule
